// File: rtl/host_seq_pkg.sv
// Shared types and helpers for the host-side BRAM sequencer.
package host_seq_pkg;

  // Sequencer states; BUSY is simply "not ST_IDLE".
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RD_OUT,
    ST_DONE
  } state_t;

  localparam logic [3:0] WE_ALL  = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

  // Word index -> byte address. The index wraps modulo 2**addr_w, so the
  // upper address bits and the two byte-lane bits always come out zero.
  function automatic logic [31:0] word2byte(input logic [31:0] word_idx,
                                            input int unsigned addr_w);
    logic [31:0] mask;
    mask = (addr_w >= 30) ? 32'h3FFF_FFFF : ((32'd1 << addr_w) - 32'd1);
    return (word_idx & mask) << 2;
  endfunction

endpackage

// File: rtl/host_bram_sequencer_stream_out_reg.sv
// Output holding register for the result stream. Once loaded, data/valid/last
// stay put until the consumer handshake clears valid.
module stream_out_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;

  // Load captures a new word; clear drops valid/last but keeps the data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      last_q  <= last_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/host_bram_sequencer.sv
// Host-side BRAM port A sequencer: loads the input stream into BRAM, starts
// the core, waits for its completion and streams the result region back.
module host_bram_sequencer
  import host_seq_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned LOAD_BASE      = 0,
  parameter int unsigned LOAD_WORDS     = 256,
  parameter int unsigned RES_BASE       = 512,
  parameter int unsigned RES_WORDS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] S_DATA,
  input  logic        S_VALID,
  input  logic        S_LAST,
  output logic        S_READY,
  output logic [31:0] M_DATA,
  output logic        M_VALID,
  output logic        M_LAST,
  input  logic        M_READY,
  output logic [31:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta,
  output logic        ena,
  output logic [3:0]  wea,
  output logic        START_SIGNAL,
  input  logic        STOP_SIGNAL,
  output logic        BUSY,
  output logic        TIMEOUT
);

  localparam int unsigned CNT_W  = $clog2(LOAD_WORDS + 1);
  localparam int unsigned RCNT_W = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(LOAD_WORDS - 1);
  localparam logic [RCNT_W-1:0] RES_LAST  = RCNT_W'(RES_WORDS - 1);
  // Only meaningful when the timeout is enabled (TIMEOUT_CYCLES != 0).
  localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic              timeout_q, timeout_d;
  logic              s_ready_q;
  logic              start_q;
  logic              s_hs;
  logic              res_last;
  logic              out_load;
  logic              out_clear;

  // Ready is a register, so the handshake never depends on S_VALID.
  assign s_hs     = S_VALID & s_ready_q;
  assign res_last = (rcnt_q == RES_LAST);

  // Next-state and counter logic for the load / run / readback sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    out_load  = 1'b0;
    out_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s_hs) begin
          timeout_d = 1'b0;
          cnt_d     = CNT_W'(1);
          state_d   = (S_LAST || (LOAD_WORDS <= 1)) ? ST_START : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (S_LAST || (cnt_q == LOAD_LAST)) begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        // A STOP still high from the previous run must drop first.
        cnt_d  = '0;
        tcnt_d = '0;
        if (!STOP_SIGNAL) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // STOP is tested first so it wins over a coincident expiry.
        if (STOP_SIGNAL) begin
          rcnt_d  = '0;
          state_d = ST_RD_REQ;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TO_LAST)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        out_load = 1'b1;
        state_d  = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (M_READY) begin
          out_clear = 1'b1;
          if (res_last) begin
            state_d = ST_DONE;
          end else begin
            rcnt_d  = rcnt_q + RCNT_W'(1);
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_DONE: begin
        if (!STOP_SIGNAL) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered handshake/start flags.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
      s_ready_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      start_q   <= (state_d == ST_START) || (state_d == ST_WAIT);
    end
  end

  // Port A: writes follow the load handshake directly, reads come from RD_REQ.
  always_comb begin
    ena   = 1'b0;
    wea   = WE_NONE;
    addra = '0;
    dina  = '0;
    if (s_hs) begin
      ena   = 1'b1;
      wea   = WE_ALL;
      addra = word2byte(32'(LOAD_BASE) + 32'(cnt_q), ADDR_W);
      dina  = S_DATA;
    end else if (state_q == ST_RD_REQ) begin
      ena   = 1'b1;
      addra = word2byte(32'(RES_BASE) + 32'(rcnt_q), ADDR_W);
    end
  end

  stream_out_reg #(
    .DATA_W(32)
  ) u_out (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .load_i (out_load),
    .clear_i(out_clear),
    .data_i (douta),
    .last_i (res_last),
    .data_o (M_DATA),
    .valid_o(M_VALID),
    .last_o (M_LAST)
  );

  assign S_READY      = s_ready_q;
  assign START_SIGNAL = start_q;
  assign BUSY         = (state_q != ST_IDLE);
  assign TIMEOUT      = timeout_q;

endmodule

// File: doc/host_bram_sequencer.md
Name: host_bram_sequencer

Overview:
- Host-side counterpart of the SIMD core's data path. It drives BRAM port A while the core owns port B.
- Loads an input stream (instructions and matrices) into BRAM and raises START_SIGNAL. It then waits for the core's STOP_SIGNAL and streams the result region back out.
- Sits between the host DMA/stream fabric and the shared true-dual-port BRAM.

Parameters:
- ADDR_W, 10: word-index width; BRAM depth is 2**ADDR_W words.
- LOAD_BASE, 0: first word index written during load.
- LOAD_WORDS, 256: maximum words accepted per load.
- RES_BASE, 512: first word index of the result region.
- RES_WORDS, 16: words returned per run.
- TIMEOUT_CYCLES, 1000000: wait limit for STOP_SIGNAL; 0 disables the limit.

Ports:
- CLK in 1: clock, rising edge.
- RSTN in 1: asynchronous active-low reset.
- S_DATA in 32: load stream data.
- S_VALID in 1: load stream valid.
- S_LAST in 1: final load word.
- S_READY out 1: load stream ready.
- M_DATA out 32: result stream data.
- M_VALID out 1: result stream valid.
- M_LAST out 1: final result word.
- M_READY in 1: result stream ready.
- addra out 32: BRAM port A byte address, equal to word index << 2.
- dina out 32: BRAM write data.
- douta in 32: BRAM read data, 1-cycle latency.
- ena out 1: BRAM port enable.
- wea out 4: byte write enables.
- START_SIGNAL out 1: level start to the core.
- STOP_SIGNAL in 1: core completion level.
- BUSY out 1: state is not IDLE.
- TIMEOUT out 1: sticky; set when TIMEOUT_CYCLES expires.

Behaviour:
- Reset (async, RSTN=0):
  - State goes to IDLE; all counters clear.
  - Outputs S_READY, M_VALID, M_LAST, ena, START_SIGNAL, BUSY and TIMEOUT are 0; wea=4'h0.
  - addra, dina and M_DATA are 0.
  - Reset mid-operation abandons the run immediately; no BRAM write completes after RSTN falls.
- States: IDLE, LOAD, START, WAIT, RD_REQ, RD_CAP, RD_OUT, DONE.
- IDLE:
  - S_READY=1.
  - The first S_VALID&S_READY handshake writes word 0 and clears TIMEOUT.
  - If that word has S_LAST=1, go to START; otherwise go to LOAD.
- LOAD:
  - S_READY=1.
  - Each handshake drives ena=1, wea=4'hF, addra=(LOAD_BASE+cnt)<<2 and dina=S_DATA in the same cycle (combinational from the handshake); then cnt++.
  - Exit to START after the handshake carrying S_LAST, or the LOAD_WORDS-th handshake, whichever comes first.
  - Words beyond LOAD_WORDS are not accepted (S_READY=0 from START onward).
  - No handshake means no write: ena=0, wea=0.
- START: START_SIGNAL=1. Remain here while STOP_SIGNAL=1 (stale done from a previous run); otherwise go to WAIT next cycle.
- WAIT:
  - START_SIGNAL=1 and the timeout counter increments.
  - When STOP_SIGNAL=1 is sampled: START_SIGNAL drops the same edge, rcnt=0, go to RD_REQ.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without STOP_SIGNAL: set TIMEOUT, drop START_SIGNAL, go to IDLE with no readback.
  - If STOP_SIGNAL and expiry coincide, STOP_SIGNAL wins.
- RD_REQ: ena=1, wea=0, addra=(RES_BASE+rcnt)<<2; go to RD_CAP.
- RD_CAP: register douta into M_DATA; M_VALID=1; M_LAST=(rcnt==RES_WORDS-1); go to RD_OUT.
- RD_OUT:
  - M_DATA, M_VALID and M_LAST are held stable until M_READY=1; the handshake then clears M_VALID.
  - If that was the last word, go to DONE; otherwise rcnt++ and go to RD_REQ.
  - Throughput is 1 word per 3 cycles at zero backpressure.
- DONE: wait for STOP_SIGNAL=0, then go to IDLE. Load-stream input is ignored here (S_READY=0).
- Address arithmetic: word indices are computed modulo 2**ADDR_W. addra[31:ADDR_W+2]=0 and addra[1:0]=0.
- Protocol rules:
  - M_VALID is never deasserted without a handshake.
  - S_READY never depends on S_VALID.

Decomposition:
- Package host_seq_pkg holds:
  - state enum state_t;
  - localparams for the write-enable patterns WE_ALL=4'hF and WE_NONE=4'h0;
  - a byte-address helper function word2byte.
- One sub-module, stream_out_reg: holding register for M_DATA/M_VALID/M_LAST with a load/clear interface.

Test Plan:
- Load with S_LAST: 4 words A0..A3, S_LAST on A3, LOAD_BASE=0 -> BRAM writes at byte addresses 0,4,8,12 with wea=F; START_SIGNAL rises the cycle after A3 is accepted.
- Run and readback: after start, pulse STOP_SIGNAL high at cycle 20 and preset BRAM[512..527]=k -> START_SIGNAL drops, M_DATA streams 0..15 with M_LAST on word 15, first read addra=2048.
- Backpressure: M_READY low for 5 cycles on word 3 -> M_DATA and M_VALID stay stable; no address advance; word order intact.
- Overflow: 300 words, no S_LAST, LOAD_WORDS=256 -> exactly 256 writes; S_READY=0 from the 257th cycle on.
- Timeout: TIMEOUT_CYCLES=50, STOP_SIGNAL held 0 -> TIMEOUT=1 and START_SIGNAL=0 at cycle 50; back in IDLE; the next load clears TIMEOUT.
- Reset mid-readback: RSTN low during RD_OUT -> M_VALID, ena and START_SIGNAL go 0 asynchronously; state IDLE; BUSY=0.
